cpu_ctrl_fsm: RTL
=================

# cpu_ctrl_fsm

Multi-cycle control sequencer for the 16-bit CPU datapath. It decodes the instruction register and steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives every datapath strobe: PC, IR, register file, ALU op, memory request handshake, and the immediate sign-extender select (short 6→16 or long 12→16 `SignExt` instance). It sits between the instruction/data memory port and the datapath mux/enable inputs.

## Interface
Parameters:
- IMM_S_W, 6, short immediate width (instr[5:0]), feeds short SignExt
- IMM_L_W, 12, long immediate width (instr[11:0]), feeds long SignExt

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr  in  16  IR contents; opcode = instr[15:12]
- zero  in  1  ALU zero flag from EXEC of BEQ
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write qualifier for mem_req (SW only)
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we, pc_we, rf_we  out  1 each  single-cycle write strobes
- pc_src  out  2  0 = PC+1, 1 = PC+sext(imm6), 2 = zext(imm12)
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR
- alu_src_b  out  1  0 = register, 1 = sign-extended immediate
- se_sel  out  1  0 = short immediate, 1 = long immediate
- rf_wsrc  out  1  0 = ALU, 1 = memory data
- state  out  3  current state encoding
- halted  out  1  sticky, set in HALT
- trap  out  1  sticky illegal-opcode flag (see Configuration)

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR (R-type); 4 ADDI, 5 LW, 6 SW, 7 BEQ (imm6); 8 JMP (imm12); F HALT; 9–E illegal.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, TRAP=7.
- IDLE → FETCH unconditionally.
- FETCH: mem_req=1, mem_addr_sel=0. Stay while !mem_ready. On mem_ready, ir_we=1 and pc_we=1 with pc_src=0 in the same cycle (Mealy), then → DECODE.
- DECODE: se_sel=1 only for JMP. HALT → HALT. Illegal opcode → TRAP (or FETCH, see Configuration). Otherwise → EXEC.
- EXEC:
  - R-type: alu_op = opcode[1:0], src_b=0 → WB.
  - ADDI/LW/SW: ADD with src_b=1 → WB (ADDI) or MEM (LW/SW).
  - BEQ: SUB with src_b=0; if zero, pc_we=1 and pc_src=1 → FETCH.
  - JMP: pc_we=1, pc_src=2 → FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for SW. Hold until mem_ready. Then SW → FETCH, LW → WB.
- WB: rf_we=1 for one cycle; rf_wsrc=1 for LW → FETCH.
- HALT: absorbing; halted=1; all strobes 0. TRAP: absorbing; trap=1; all strobes 0.
- se_sel and alu_src_b remain valid from DECODE through WB of the same instruction.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE; every output 0, including halted and trap.
- Reset deassert → IDLE for 1 cycle → FETCH; mem_req rises on the 2nd edge after release.
- Latency with zero-wait memory (mem_ready in the first request cycle):
  - R-type/ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/JMP: 3 cycles.
- Each wait cycle adds 1 cycle.
- mem_req/mem_we/mem_addr_sel stay stable while mem_ready is low. mem_ready outside FETCH/MEM is ignored.
- Strobes (ir_we, pc_we, rf_we) are asserted for exactly one cycle per instruction. A taken BEQ asserts pc_we twice (FETCH, EXEC); a not-taken BEQ asserts it once.
- Reset mid-instruction aborts immediately; no partial strobe survives past rst_n fall.

## Configuration
- CTRL_TRAP_EN defined: illegal opcode in DECODE → TRAP. trap=1, sticky until reset.
- Undefined: illegal opcode executes as a NOP (DECODE → FETCH); the trap port is tied 0 and state never equals 7.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants (OP_ADD…OP_HALT)
  - state encoding constants
  - alu_op and pc_src encodings, also consumed by the ALU and PC mux
- One sub-module, cpu_ctrl_decode: combinational opcode → {class, alu_op, se_sel, is_illegal}. The FSM and output logic stay in cpu_ctrl_fsm.

## Test plan
- Reset: rst_n low mid-MEM of an LW → all outputs 0 and state=0 asynchronously; after release, state 0→1 and mem_req=1 two edges later.
- ADD (instr=16'h0123), zero-wait memory → ir_we+pc_we in FETCH, alu_op=0/src_b=0 in EXEC, rf_we in WB; next FETCH on cycle 5.
- LW (16'h5105) with mem_ready low for 3 cycles in MEM → mem_req/mem_addr_sel=1 held 4 cycles, then rf_we=1 with rf_wsrc=1.
- BEQ (16'h7012) zero=1 → pc_we=1 and pc_src=1 in EXEC; repeat with zero=0 → no pc_we in EXEC. JMP (16'h8ABC) → se_sel=1, pc_src=2.
- HALT (16'hF000) → state=6, halted=1, no strobes for 20 cycles despite mem_ready toggling.
- Opcode 16'h9000: with CTRL_TRAP_EN → state=7, trap=1; without it → back to FETCH, trap=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the 16-bit CPU control path
//
// Opcodes, control-FSM state encoding, instruction classes, and the
// alu_op / pc_src encodings that the ALU and PC mux decode as well.

package cpu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_ADDI = 3'd1,
        CLS_LW   = 3'd2,
        CLS_SW   = 3'd3,
        CLS_BEQ  = 3'd4,
        CLS_JMP  = 3'd5,
        CLS_HALT = 3'd6,
        CLS_ILL  = 3'd7
    } cls_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    localparam logic [1:0] PC_INC    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// rtl/cpu_ctrl_decode.sv - combinational opcode decoder for the control FSM
//
// Ports:
//   opcode      in  4  instr[15:12]
//   cls         out 3  instruction class (cls_t)
//   alu_op      out 3  ALU operation used in EXEC
//   se_sel      out 1  1 = long (12-bit) immediate, JMP only
//   is_illegal  out 1  opcode 9..E

module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output cls_t       cls,
    output logic [2:0] alu_op,
    output logic       se_sel,
    output logic       is_illegal
);

    always_comb begin
        cls        = CLS_ILL;
        alu_op     = ALU_ADD;
        se_sel     = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                cls    = CLS_R;
                // R-type opcodes line up with the ALU encoding
                alu_op = {1'b0, opcode[1:0]};
            end
            OP_ADDI: cls = CLS_ADDI;
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_BEQ: begin
                cls    = CLS_BEQ;
                alu_op = ALU_SUB;
            end
            OP_JMP: begin
                cls    = CLS_JMP;
                se_sel = 1'b1;
            end
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_ILL;
        endcase
        is_illegal = (cls == CLS_ILL);
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle control sequencer for the 16-bit CPU
//
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath strobes. Optional feature macro: CTRL_TRAP_EN (illegal opcode
// enters the absorbing TRAP state; otherwise it is executed as a NOP).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   instr[15:0]         IR contents, opcode = instr[15:12]
//   zero                ALU zero flag (BEQ in EXEC)
//   mem_ready           memory completes the current request
//   mem_req/mem_we      memory request / write qualifier (held until ready)
//   mem_addr_sel        0 = PC, 1 = ALU result
//   ir_we/pc_we/rf_we   single-cycle write strobes
//   pc_src[1:0]         0 = PC+1, 1 = PC+sext(imm6), 2 = zext(imm12)
//   alu_op[2:0]         0 ADD, 1 SUB, 2 AND, 3 OR
//   alu_src_b, se_sel   B-operand select, long/short immediate select
//   rf_wsrc             0 = ALU, 1 = memory data
//   state[2:0]          current state encoding
//   halted, trap        sticky status flags

module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int IMM_S_W = 6,
    parameter int IMM_L_W = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic [1:0]  pc_src,
    output logic [2:0]  alu_op,
    output logic        alu_src_b,
    output logic        se_sel,
    output logic        rf_wsrc,
    output logic [2:0]  state,
    output logic        halted,
    output logic        trap
);

    state_t     st;
    logic       armed;
    cls_t       cls;
    logic [2:0] dec_alu_op;
    logic       dec_se_sel;
    logic       dec_illegal;

    // Immediate bits feed the datapath sign-extenders directly; the
    // controller only chooses between them.
    logic unused_imm;
    assign unused_imm = ^{instr[IMM_L_W-1:IMM_S_W], instr[IMM_S_W-1:0]};

    cpu_ctrl_decode u_decode (
        .opcode     (instr[15:12]),
        .cls        (cls),
        .alu_op     (dec_alu_op),
        .se_sel     (dec_se_sel),
        .is_illegal (dec_illegal)
    );

`ifdef CTRL_TRAP_EN
    logic trap_q;
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    // Memory and register-file controls are registered alongside the
    // state so they change only on the edge that enters the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= ST_IDLE;
            armed        <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr_sel <= 1'b0;
            rf_we        <= 1'b0;
            rf_wsrc      <= 1'b0;
            halted       <= 1'b0;
`ifdef CTRL_TRAP_EN
            trap_q       <= 1'b0;
`endif
        end else begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr_sel <= 1'b0;
            rf_we        <= 1'b0;
            rf_wsrc      <= 1'b0;
            case (st)
                // First edge after reset release only arms; IDLE then
                // lasts one full cycle before the first fetch.
                ST_IDLE: begin
                    armed <= 1'b1;
                    if (armed) begin
                        st      <= ST_FETCH;
                        mem_req <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (mem_ready) st <= ST_DECODE;
                    else           mem_req <= 1'b1;
                end
                ST_DECODE: begin
                    if (cls == CLS_HALT) begin
                        st     <= ST_HALT;
                        halted <= 1'b1;
                    end else if (dec_illegal) begin
`ifdef CTRL_TRAP_EN
                        st     <= ST_TRAP;
                        trap_q <= 1'b1;
`else
                        st      <= ST_FETCH;
                        mem_req <= 1'b1;
`endif
                    end else begin
                        st <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (cls)
                        CLS_LW, CLS_SW: begin
                            st           <= ST_MEM;
                            mem_req      <= 1'b1;
                            mem_addr_sel <= 1'b1;
                            mem_we       <= (cls == CLS_SW);
                        end
                        CLS_BEQ, CLS_JMP: begin
                            st      <= ST_FETCH;
                            mem_req <= 1'b1;
                        end
                        default: begin
                            st    <= ST_WB;
                            rf_we <= 1'b1;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        if (cls == CLS_SW) begin
                            st      <= ST_FETCH;
                            mem_req <= 1'b1;
                        end else begin
                            st      <= ST_WB;
                            rf_we   <= 1'b1;
                            rf_wsrc <= 1'b1;
                        end
                    end else begin
                        mem_req      <= 1'b1;
                        mem_addr_sel <= 1'b1;
                        mem_we       <= mem_we;
                    end
                end
                ST_WB: begin
                    st      <= ST_FETCH;
                    mem_req <= 1'b1;
                end
                ST_HALT: st <= ST_HALT;
                ST_TRAP: st <= ST_TRAP;
                default: st <= ST_IDLE;
            endcase
        end
    end

    logic in_fetch;
    logic in_exec;
    logic in_instr;
    logic beq_taken;
    logic jmp_exec;

    assign in_fetch  = (st == ST_FETCH);
    assign in_exec   = (st == ST_EXEC);
    assign in_instr  = (st inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB});
    assign beq_taken = in_exec && (cls == CLS_BEQ) && zero;
    assign jmp_exec  = in_exec && (cls == CLS_JMP);

    // IR/PC strobes complete with the memory handshake or the branch
    // resolution in the same cycle, so they cannot be registered.
    assign ir_we     = in_fetch && mem_ready;
    assign pc_we     = ir_we || beq_taken || jmp_exec;
    assign alu_op    = in_exec ? dec_alu_op : ALU_ADD;
    assign se_sel    = in_instr && dec_se_sel;
    assign alu_src_b = in_instr && (cls inside {CLS_ADDI, CLS_LW, CLS_SW});

    always_comb begin
        pc_src = PC_INC;
        if (beq_taken)     pc_src = PC_BRANCH;
        else if (jmp_exec) pc_src = PC_JUMP;
    end

    assign state = st;

endmodule
